// File: rtl/rpc_ref_timer.sv
// rpc_ref_timer: periodic DRAM refresh request generator.
// Counts a programmable interval while initialization is done and the timer is
// enabled. On each period boundary it registers a refresh command and raises
// cmd_valid_o one cycle later, holding it until the arbiter accepts it.
// Optional feature: define RPC_REF_POSTPONE_EN to queue up to MaxPending
// refreshes that expire while a request is still waiting. Without it, such a
// refresh is dropped and only flagged on overflow_o.
// state_o exposes the FSM (0 = IDLE, 1 = COUNT, 2 = REQ) for debug and checkers.
module rpc_ref_timer #(
    parameter int MaxPending = 8,
    parameter int CmdWidth   = 19
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                init_done_i,
    input  logic [31:0]         cfg_i,
    output logic [CmdWidth-1:0] cmd_o,
    output logic                cmd_valid_o,
    input  logic                cmd_ready_i,
    output logic [3:0]          pending_o,
    output logic                overflow_o,
    output logic [1:0]          state_o
);

    // Handshake: cmd_o is transferred on a rising edge where cmd_valid_o and
    // cmd_ready_i are both high. Once raised, cmd_valid_o and cmd_o hold their
    // values until that transfer; cmd_ready_i may toggle freely.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_REQ   = 2'd2
    } state_e;

`ifdef RPC_REF_POSTPONE_EN
    localparam bit PostponeEn = 1'b1;
`else
    localparam bit PostponeEn = 1'b0;
`endif
    // A cap of zero makes every refresh that expires during a request overflow.
    localparam logic [3:0] PendCap = PostponeEn ? 4'(MaxPending) : 4'd0;

    state_e                state_q;
    logic [31:0]           cnt_q;
    logic [CmdWidth-1:0]   cmd_q;
    logic                  valid_q;
    logic [3:0]            pending_q;
    logic                  overflow_q;

    logic                  running;
    logic [31:0]           period;
    logic                  tick;
    logic                  hs;
    logic [CmdWidth-1:0]   cmd_next;

    assign running = init_done_i & cfg_i[31];
    // An interval of zero behaves like an interval of one.
    assign period  = (cfg_i[24:0] == 25'd0) ? 32'd1 : {7'd0, cfg_i[24:0]};
    // ">=" lets a shrunk interval fire on the very next edge.
    assign tick    = running && (cnt_q >= (period - 32'd1));
    assign hs      = valid_q & cmd_ready_i;

    // Build the refresh command word: type 2'b01 on top, refop and bank list at the bottom.
    always_comb begin
        cmd_next                    = '0;
        cmd_next[CmdWidth-1 -: 2]   = 2'b01;
        cmd_next[5:0]               = cfg_i[30:25];
    end

    // Interval counter, request FSM, pending count and sticky overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 32'd0;
            cmd_q      <= '0;
            valid_q    <= 1'b0;
            pending_q  <= 4'd0;
            overflow_q <= 1'b0;
        end else begin
            if (!running || tick) cnt_q <= 32'd0;
            else                  cnt_q <= cnt_q + 32'd1;

            // Postponed refreshes are discarded as soon as the timer stops.
            if (!running) pending_q <= 4'd0;

            case (state_q)
                // A period boundary seen while leaving IDLE only arms the timer.
                ST_IDLE: begin
                    if (running) state_q <= ST_COUNT;
                end
                ST_COUNT: begin
                    if (!running) begin
                        state_q <= ST_IDLE;
                    end else if (tick) begin
                        state_q <= ST_REQ;
                        cmd_q   <= cmd_next;
                        valid_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (hs) begin
                        if (!running) begin
                            state_q <= ST_IDLE;
                            valid_q <= 1'b0;
                        end else if (tick) begin
                            cmd_q <= cmd_next;
                        end else if (pending_q != 4'd0) begin
                            pending_q <= pending_q - 4'd1;
                            cmd_q     <= cmd_next;
                        end else begin
                            state_q <= ST_COUNT;
                            valid_q <= 1'b0;
                        end
                    end else if (tick) begin
                        if (pending_q == PendCap) overflow_q <= 1'b1;
                        else                      pending_q  <= pending_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_o       = cmd_q;
    assign cmd_valid_o = valid_q;
    assign pending_o   = pending_q;
    assign overflow_o  = overflow_q;
    assign state_o     = state_q;

endmodule
